jelly_rtos_ready_queue: RTL and testbench
=========================================

# jelly_rtos_ready_queue

Ready-queue and top-of-queue selector for the Jelly RTOS core; it sits on the other side of the per-task `req_rdq` / `rdy_tsk` handshake. It collects ready requests from all task state machines, acknowledges each with a one-cycle `rdy_tsk` pulse, and keeps a bitmap of READY tasks. It reports the highest-priority READY task to the dispatcher every cycle. Tasks leave the queue through an explicit remove command issued alongside the service-call that takes them out of READY.

## Interface
Parameters:
- `TASKS`, 8, number of task state machines served; must satisfy TASKS ≤ 2**TSKID_WIDTH.
- `TSKID_WIDTH`, 4, task ID width.
- `TSKPRI_WIDTH`, 4, priority width; a smaller value means a higher priority.

Ports:
- `reset_n`  input  1  asynchronous, active-low reset.
- `clk`  input  1  single clock, rising edge.
- `cke`  input  1  clock enable; when low, all state and registered outputs hold.
- `busy`  output  1  combinational: at least one request is pending and not yet acknowledged.
- `task_req_rdq`  input  TASKS  per-task ready request (registered in each task).
- `task_tskpri`  input  TASKS*TSKPRI_WIDTH  per-task priority; task i occupies bits [i*TSKPRI_WIDTH +: TSKPRI_WIDTH].
- `task_rdy_tsk`  output  TASKS  per-task acknowledge pulse; the task enters READY on the edge that ends the pulse cycle.
- `rmv_tskid`  input  TSKID_WIDTH  task to remove from the ready bitmap.
- `rmv_valid`  input  1  remove strobe.
- `top_valid`  output  1  at least one task is READY.
- `top_tskid`  output  TSKID_WIDTH  highest-priority READY task.
- `top_tskpri`  output  TSKPRI_WIDTH  priority of `top_tskid`.
- `ready_bitmap`  output  TASKS  current READY set (debug / status).

## Operation
- State consists of `ready` (TASKS bits), `rdy_tsk` register (TASKS bits), and the `top_*` registers.
- Pending set: `pend = task_req_rdq & ~ready & ~rdy_tsk`. The `~rdy_tsk` term masks the one cycle in which a task's `req_rdq` is still high after its acknowledge.
- All pending tasks are accepted in parallel in the same cycle; there is no per-cycle limit.
- On each `cke` edge:
  - `rdy_tsk <= pend`.
  - `ready_next = (ready & ~rmv_mask) | pend`, where `rmv_mask` is one-hot on `rmv_tskid` when `rmv_valid` is high and all-zero otherwise.
  - `ready <= ready_next`.
- Accept beats remove for the same task in the same cycle: the task ends up READY, matching the task FSM, where `rdy_tsk` overrides all service calls.
- If `rmv_tskid` ≥ TASKS, the remove is ignored.
- Remove of a task that is not READY is a no-op.
- Top selection is combinational over `ready_next` and the current `task_tskpri`:
  - Pick the minimum priority value; ties go to the lowest task index.
  - Implement as a balanced compare tree (log2 TASKS levels).
  - Register the result into `top_*`.
  - If `ready_next` is zero: `top_valid <= 0`; `top_tskid` and `top_tskpri` hold their previous values.
- `busy = |pend`, combinational.

## Timing
- Reset (asynchronous assert, release synchronized by the system): `ready=0`, `task_rdy_tsk=0`, `top_valid=0`, `top_tskid=0`, `top_tskpri=0`, `ready_bitmap=0`. `busy` follows its inputs.
- Request to acknowledge: `task_req_rdq` high in cycle t → `task_rdy_tsk` high in cycle t+1 (exactly one cycle) → task READY from t+2. In t+1 the `req_rdq` is still high and is masked; it drops in t+2.
- `ready` bit and `top_*` update in the same cycle the `rdy_tsk` pulse is visible (t+1).
- Remove: `rmv_valid` in cycle t → `ready` bit clear and `top_*` re-evaluated at t+1.
- Priority change on `task_tskpri` in cycle t → reflected in `top_*` at t+1.
- `cke` low: no state changes, `rdy_tsk` pulse is stretched, `busy` still combinational. The task FSMs share the same `cke`, so the handshake stays aligned.
- Reset mid-handshake clears `rdy_tsk` immediately; a task still requesting is re-accepted after reset release.

## Test plan
- **Reset:** assert `reset_n=0` mid-cycle → all outputs 0 asynchronously. Release with `task_req_rdq=8'h00` → `top_valid=0`, `busy=0`.
- **Single request:** task 3 (pri 5) raises `req_rdq` for 2 cycles → `task_rdy_tsk=8'h08` for exactly one cycle; `top_valid=1`, `top_tskid=3`, `top_tskpri=5` the same cycle; no second pulse.
- **Parallel accept and priority:** tasks 1, 4, 6 with pri 7, 2, 2 request in the same cycle → `rdy_tsk=8'h52`; `top_tskid=4` (tie on 2 resolved to the lower index); `ready_bitmap=8'h52`.
- **Remove:** from the previous state, `rmv_tskid=4` → `top_tskid=6` next cycle. Then remove 6, then 1 → `top_valid=0`, `top_tskid` holds 1.
- **Simultaneous accept and remove:** task 2 requests while `rmv_tskid=2` is strobed → task 2 is READY; `rdy_tsk` bit 2 pulses. `rmv_tskid=9` → no change.
- **`cke` and priority change:** hold `cke=0` for 3 cycles during a pending request → no pulse and `busy=1`; then `cke=1` → pulse. Change task 6 pri from 2 to 0 while task 4 (pri 1) is READY → `top_tskid=6` one cycle later.

Source files
------------

// File: rtl/jelly_rtos_ready_queue.sv
//==============================================================================
// Module      : jelly_rtos_ready_queue
// Description : Ready-queue for the Jelly RTOS core. Acknowledges per-task
//               ready requests, tracks the READY bitmap and reports the
//               highest-priority READY task every cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module jelly_rtos_ready_queue #(
    parameter int TASKS        = 8,
    parameter int TSKID_WIDTH  = 4,
    parameter int TSKPRI_WIDTH = 4
) (
    input  logic                            reset_n,
    input  logic                            clk,
    input  logic                            cke,

    output logic                            busy,

    input  logic [TASKS-1:0]                task_req_rdq,
    input  logic [TASKS*TSKPRI_WIDTH-1:0]   task_tskpri,
    output logic [TASKS-1:0]                task_rdy_tsk,

    input  logic [TSKID_WIDTH-1:0]          rmv_tskid,
    input  logic                            rmv_valid,

    output logic                            top_valid,
    output logic [TSKID_WIDTH-1:0]          top_tskid,
    output logic [TSKPRI_WIDTH-1:0]         top_tskpri,
    output logic [TASKS-1:0]                ready_bitmap
);

    // The compare tree is padded to a power-of-two number of leaves and
    // stored heap-style: node n has children 2n+1 and 2n+2, node 0 is the root.
    localparam int C_LEVELS = (TASKS > 1) ? $clog2(TASKS) : 0;
    localparam int C_LEAVES = 1 << C_LEVELS;
    localparam int C_NODES  = 2 * C_LEAVES - 1;

    logic [TASKS-1:0]           ready_q;
    logic [TASKS-1:0]           ready_d;
    logic [TASKS-1:0]           rdy_tsk_q;
    logic [TASKS-1:0]           rdy_tsk_d;
    logic                       top_valid_q;
    logic                       top_valid_d;
    logic [TSKID_WIDTH-1:0]     top_tskid_q;
    logic [TSKID_WIDTH-1:0]     top_tskid_d;
    logic [TSKPRI_WIDTH-1:0]    top_tskpri_q;
    logic [TSKPRI_WIDTH-1:0]    top_tskpri_d;

    logic [TASKS-1:0]           w_pend;
    logic [TASKS-1:0]           w_rmv_mask;

    logic                       w_node_valid [C_NODES];
    logic [TSKID_WIDTH-1:0]     w_node_id    [C_NODES];
    logic [TSKPRI_WIDTH-1:0]    w_node_pri   [C_NODES];

    // An out-of-range rmv_tskid matches no bit, so it is silently ignored.
    always_comb begin
        w_rmv_mask = '0;
        for (int i = 0; i < TASKS; i++) begin
            if (rmv_valid && (rmv_tskid == TSKID_WIDTH'(i))) begin
                w_rmv_mask[i] = 1'b1;
            end
        end
    end

    // rdy_tsk_q masks the cycle where a task still holds req_rdq after its ack.
    assign w_pend = task_req_rdq & ~ready_q & ~rdy_tsk_q;

    generate
        for (genvar g = 0; g < C_LEAVES; g++) begin : g_leaf
            if (g < TASKS) begin : g_task
                assign w_node_valid[C_LEAVES-1+g] = ready_d[g];
                assign w_node_id[C_LEAVES-1+g]    = TSKID_WIDTH'(g);
                assign w_node_pri[C_LEAVES-1+g]   = task_tskpri[g*TSKPRI_WIDTH +: TSKPRI_WIDTH];
            end else begin : g_pad
                assign w_node_valid[C_LEAVES-1+g] = 1'b0;
                assign w_node_id[C_LEAVES-1+g]    = '0;
                assign w_node_pri[C_LEAVES-1+g]   = '0;
            end
        end

        // Left subtree always holds the lower task indices, so ties favour it.
        for (genvar n = 0; n < C_LEAVES - 1; n++) begin : g_node
            logic w_pick_left;
            assign w_pick_left = w_node_valid[2*n+1] &&
                                 (!w_node_valid[2*n+2] ||
                                  (w_node_pri[2*n+1] <= w_node_pri[2*n+2]));
            assign w_node_valid[n] = w_node_valid[2*n+1] | w_node_valid[2*n+2];
            assign w_node_id[n]    = w_pick_left ? w_node_id[2*n+1]  : w_node_id[2*n+2];
            assign w_node_pri[n]   = w_pick_left ? w_node_pri[2*n+1] : w_node_pri[2*n+2];
        end
    endgenerate

    // Accept is OR-ed in after the remove mask, so accept wins on a collision.
    always_comb begin
        rdy_tsk_d    = w_pend;
        ready_d      = (ready_q & ~w_rmv_mask) | w_pend;
        top_valid_d  = w_node_valid[0];
        top_tskid_d  = top_tskid_q;
        top_tskpri_d = top_tskpri_q;
        if (w_node_valid[0]) begin
            top_tskid_d  = w_node_id[0];
            top_tskpri_d = w_node_pri[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q      <= '0;
            rdy_tsk_q    <= '0;
            top_valid_q  <= 1'b0;
            top_tskid_q  <= '0;
            top_tskpri_q <= '0;
        end else if (cke) begin
            ready_q      <= ready_d;
            rdy_tsk_q    <= rdy_tsk_d;
            top_valid_q  <= top_valid_d;
            top_tskid_q  <= top_tskid_d;
            top_tskpri_q <= top_tskpri_d;
        end
    end

    assign busy         = |w_pend;
    assign task_rdy_tsk = rdy_tsk_q;
    assign ready_bitmap = ready_q;
    assign top_valid    = top_valid_q;
    assign top_tskid    = top_tskid_q;
    assign top_tskpri   = top_tskpri_q;

endmodule

`default_nettype wire

// File: tb/tb_jelly_rtos_ready_queue.sv
//==============================================================================
// Module      : tb_jelly_rtos_ready_queue
// Description : Scenario-based scoreboard bench for the ready queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jelly_rtos_ready_queue;

    localparam int TASKS = 8;
    localparam int TW    = 4;
    localparam int PW    = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                cke;
    logic                busy;
    logic [TASKS-1:0]    req;
    logic [TASKS*PW-1:0] pri;
    logic [TASKS-1:0]    rdy;
    logic [TW-1:0]       rmv_id;
    logic                rmv_v;
    logic                tv;
    logic [TW-1:0]       tid;
    logic [PW-1:0]       tpri;
    logic [TASKS-1:0]    bm;

    always #5 clk = ~clk;

    jelly_rtos_ready_queue #(
        .TASKS        (TASKS),
        .TSKID_WIDTH  (TW),
        .TSKPRI_WIDTH (PW)
    ) u_dut (
        .reset_n      (reset_n),
        .clk          (clk),
        .cke          (cke),
        .busy         (busy),
        .task_req_rdq (req),
        .task_tskpri  (pri),
        .task_rdy_tsk (rdy),
        .rmv_tskid    (rmv_id),
        .rmv_valid    (rmv_v),
        .top_valid    (tv),
        .top_tskid    (tid),
        .top_tskpri   (tpri),
        .ready_bitmap (bm)
    );

    typedef struct packed {
        logic [7:0] rdy;
        logic [7:0] bm;
        logic       tv;
        logic [3:0] tid;
        logic [3:0] tpri;
        logic       bsy;
    } snap_t;

    typedef struct {
        logic [7:0] req;
        logic       rv;
        logic [3:0] rid;
        logic       ce;
        snap_t      exp;
    } step_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic snap_t mk(input logic [7:0] r, input logic [7:0] b, input logic v,
                                 input logic [3:0] id, input logic [3:0] p, input logic bz);
        snap_t s;
        s.rdy = r; s.bm = b; s.tv = v; s.tid = id; s.tpri = p; s.bsy = bz;
        return s;
    endfunction

    function automatic snap_t observe();
        return mk(rdy, bm, tv, tid, tpri, busy);
    endfunction

    function automatic step_t st(input logic [7:0] r, input logic v, input logic [3:0] id,
                                 input logic ce, input snap_t e);
        step_t s;
        s.req = r; s.rv = v; s.rid = id; s.ce = ce; s.exp = e;
        return s;
    endfunction

    task automatic set_pri(input int i, input logic [3:0] p);
        pri[i*PW +: PW] = p;
    endtask

    task automatic test_reset();
        snap_t o, e;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0));
        #1;
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_async: actual %h required %h", o, e);
        end
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0));
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_hold: actual %h required %h", o, e);
        end
        reset_n = 1'b1;
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 1'b0));
        @(posedge clk); #1;
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_release: actual %h required %h", o, e);
        end
    endtask

    task automatic test_single();
        step_t s[$];
        snap_t o, e;
        s.push_back(st(8'h08, 1'b0, 4'd0, 1'b1, mk(8'h08, 8'h08, 1'b1, 4'd3, 4'd5, 1'b0)));
        s.push_back(st(8'h08, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h08, 1'b1, 4'd3, 4'd5, 1'b0)));
        s.push_back(st(8'h00, 1'b1, 4'd3, 1'b1, mk(8'h00, 8'h00, 1'b0, 4'd3, 4'd5, 1'b0)));
        s.push_back(st(8'h00, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h00, 1'b0, 4'd3, 4'd5, 1'b0)));
        foreach (s[i]) begin
            req = s[i].req; rmv_v = s[i].rv; rmv_id = s[i].rid; cke = s[i].ce;
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single[%0d]: actual rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b required rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b",
                         i, o.rdy, o.bm, o.tv, o.tid, o.tpri, o.bsy, e.rdy, e.bm, e.tv, e.tid, e.tpri, e.bsy);
            end
        end
    endtask

    task automatic test_parallel();
        step_t s[$];
        snap_t o, e;
        s.push_back(st(8'h52, 1'b0, 4'd0, 1'b1, mk(8'h52, 8'h52, 1'b1, 4'd4, 4'd2, 1'b0)));
        s.push_back(st(8'h52, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h52, 1'b1, 4'd4, 4'd2, 1'b0)));
        s.push_back(st(8'h00, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h52, 1'b1, 4'd4, 4'd2, 1'b0)));
        foreach (s[i]) begin
            req = s[i].req; rmv_v = s[i].rv; rmv_id = s[i].rid; cke = s[i].ce;
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL parallel[%0d]: actual rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b required rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b",
                         i, o.rdy, o.bm, o.tv, o.tid, o.tpri, o.bsy, e.rdy, e.bm, e.tv, e.tid, e.tpri, e.bsy);
            end
        end
    endtask

    task automatic test_remove();
        step_t s[$];
        snap_t o, e;
        s.push_back(st(8'h00, 1'b1, 4'd4, 1'b1, mk(8'h00, 8'h42, 1'b1, 4'd6, 4'd2, 1'b0)));
        s.push_back(st(8'h00, 1'b1, 4'd6, 1'b1, mk(8'h00, 8'h02, 1'b1, 4'd1, 4'd7, 1'b0)));
        s.push_back(st(8'h00, 1'b1, 4'd1, 1'b1, mk(8'h00, 8'h00, 1'b0, 4'd1, 4'd7, 1'b0)));
        s.push_back(st(8'h00, 1'b1, 4'd5, 1'b1, mk(8'h00, 8'h00, 1'b0, 4'd1, 4'd7, 1'b0)));
        s.push_back(st(8'h00, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h00, 1'b0, 4'd1, 4'd7, 1'b0)));
        foreach (s[i]) begin
            req = s[i].req; rmv_v = s[i].rv; rmv_id = s[i].rid; cke = s[i].ce;
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL remove[%0d]: actual rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b required rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b",
                         i, o.rdy, o.bm, o.tv, o.tid, o.tpri, o.bsy, e.rdy, e.bm, e.tv, e.tid, e.tpri, e.bsy);
            end
        end
    endtask

    task automatic test_accept_remove();
        step_t s[$];
        snap_t o, e;
        s.push_back(st(8'h04, 1'b1, 4'd2, 1'b1, mk(8'h04, 8'h04, 1'b1, 4'd2, 4'd3, 1'b0)));
        s.push_back(st(8'h04, 1'b1, 4'd9, 1'b1, mk(8'h00, 8'h04, 1'b1, 4'd2, 4'd3, 1'b0)));
        s.push_back(st(8'h00, 1'b1, 4'd9, 1'b1, mk(8'h00, 8'h04, 1'b1, 4'd2, 4'd3, 1'b0)));
        s.push_back(st(8'h00, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h04, 1'b1, 4'd2, 4'd3, 1'b0)));
        foreach (s[i]) begin
            req = s[i].req; rmv_v = s[i].rv; rmv_id = s[i].rid; cke = s[i].ce;
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL accept_remove[%0d]: actual rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b required rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b",
                         i, o.rdy, o.bm, o.tv, o.tid, o.tpri, o.bsy, e.rdy, e.bm, e.tv, e.tid, e.tpri, e.bsy);
            end
        end
    endtask

    task automatic test_cke_pri();
        step_t s[$];
        snap_t o, e;
        set_pri(4, 4'd1);
        s.push_back(st(8'h10, 1'b0, 4'd0, 1'b0, mk(8'h00, 8'h04, 1'b1, 4'd2, 4'd3, 1'b1)));
        s.push_back(st(8'h10, 1'b0, 4'd0, 1'b0, mk(8'h00, 8'h04, 1'b1, 4'd2, 4'd3, 1'b1)));
        s.push_back(st(8'h10, 1'b0, 4'd0, 1'b0, mk(8'h00, 8'h04, 1'b1, 4'd2, 4'd3, 1'b1)));
        s.push_back(st(8'h10, 1'b0, 4'd0, 1'b1, mk(8'h10, 8'h14, 1'b1, 4'd4, 4'd1, 1'b0)));
        s.push_back(st(8'h10, 1'b0, 4'd0, 1'b0, mk(8'h10, 8'h14, 1'b1, 4'd4, 4'd1, 1'b0)));
        s.push_back(st(8'h10, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h14, 1'b1, 4'd4, 4'd1, 1'b0)));
        s.push_back(st(8'h40, 1'b0, 4'd0, 1'b1, mk(8'h40, 8'h54, 1'b1, 4'd4, 4'd1, 1'b0)));
        s.push_back(st(8'h40, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h54, 1'b1, 4'd4, 4'd1, 1'b0)));
        s.push_back(st(8'h00, 1'b0, 4'd0, 1'b1, mk(8'h00, 8'h54, 1'b1, 4'd6, 4'd0, 1'b0)));
        foreach (s[i]) begin
            req = s[i].req; rmv_v = s[i].rv; rmv_id = s[i].rid; cke = s[i].ce;
            if (i == 8) set_pri(6, 4'd0);
            exp_q.push_back(s[i].exp);
            @(posedge clk); #1;
            o = observe(); e = exp_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL cke_pri[%0d]: actual rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b required rdy=%h bm=%h tv=%b id=%0d pri=%0d busy=%b",
                         i, o.rdy, o.bm, o.tv, o.tid, o.tpri, o.bsy, e.rdy, e.bm, e.tv, e.tid, e.tpri, e.bsy);
            end
        end
    endtask

    task automatic test_reset_mid();
        snap_t o, e;
        req = 8'h01; rmv_v = 1'b0; cke = 1'b1;
        exp_q.push_back(mk(8'h01, 8'h55, 1'b1, 4'd6, 4'd0, 1'b0));
        @(posedge clk); #1;
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_accept: actual %h required %h", o, e);
        end
        #3 reset_n = 1'b0;
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 1'b1));
        #1;
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_async: actual %h required %h", o, e);
        end
        @(posedge clk); #1;
        exp_q.push_back(mk(8'h00, 8'h00, 1'b0, 4'd0, 4'd0, 1'b1));
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_hold: actual %h required %h", o, e);
        end
        reset_n = 1'b1;
        exp_q.push_back(mk(8'h01, 8'h01, 1'b1, 4'd0, 4'd9, 1'b0));
        @(posedge clk); #1;
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_reaccept: actual %h required %h", o, e);
        end
        req = 8'h00;
        exp_q.push_back(mk(8'h00, 8'h01, 1'b1, 4'd0, 4'd9, 1'b0));
        @(posedge clk); #1;
        o = observe(); e = exp_q.pop_front(); n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_settle: actual %h required %h", o, e);
        end
    endtask

    initial begin
        cke    = 1'b1;
        req    = '0;
        rmv_v  = 1'b0;
        rmv_id = '0;
        pri    = {TASKS*PW{1'b1}};
        set_pri(0, 4'd9);
        set_pri(1, 4'd7);
        set_pri(2, 4'd3);
        set_pri(3, 4'd5);
        set_pri(4, 4'd2);
        set_pri(6, 4'd2);

        test_reset();
        test_single();
        test_parallel();
        test_remove();
        test_accept_remove();
        test_cke_pri();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
